// File: rtl/updown_mod_counter.sv
// rtl/updown_mod_counter.sv - modulo up/down counter with Gray output and boundary event flags
module updown_mod_counter #(
    parameter int WIDTH    = 8,
    parameter int MAX_VAL  = 255,
    parameter int SATURATE = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             clr,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_gray,
    output logic             wrap_p,
    output logic             ovf
);

    localparam logic [WIDTH-1:0] MAX_Q  = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] ZERO_Q = '0;
    localparam logic [WIDTH-1:0] ONE_Q  = WIDTH'(1);
    localparam bit               SAT    = (SATURATE != 0);

    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] q_gray_q, q_gray_d;
    logic             wrap_p_q, wrap_p_d;
    logic             ovf_q, ovf_d;

    always_comb begin
        q_d      = q_q;
        wrap_p_d = 1'b0;
        ovf_d    = ovf_q;
        if (clr) begin
            q_d   = ZERO_Q;
            ovf_d = 1'b0;
        end else if (load) begin
            q_d = (load_val > MAX_Q) ? MAX_Q : load_val;
        end else if (en) begin
            if (up) begin
                if (q_q == MAX_Q) begin
                    wrap_p_d = 1'b1;
                    ovf_d    = 1'b1;
                    q_d      = SAT ? MAX_Q : ZERO_Q;
                end else begin
                    q_d = q_q + ONE_Q;
                end
            end else begin
                if (q_q == ZERO_Q) begin
                    wrap_p_d = 1'b1;
                    ovf_d    = 1'b1;
                    q_d      = SAT ? ZERO_Q : MAX_Q;
                end else begin
                    q_d = q_q - ONE_Q;
                end
            end
        end
        // Gray is encoded from the next-state count so it lands on the same edge as q.
        q_gray_d = (q_d >> 1) ^ q_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q      <= '0;
            q_gray_q <= '0;
            wrap_p_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            q_q      <= q_d;
            q_gray_q <= q_gray_d;
            wrap_p_q <= wrap_p_d;
            ovf_q    <= ovf_d;
        end
    end

    assign q      = q_q;
    assign q_gray = q_gray_q;
    assign wrap_p = wrap_p_q;
    assign ovf    = ovf_q;

endmodule

// File: tb/tb_updown_mod_counter.sv
// tb/tb_updown_mod_counter.sv - directed and randomized checks of a wrap and a saturating counter
module tb_updown_mod_counter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en, up, load, clr;
    logic [3:0] load_val;
    logic [3:0] q_w, g_w, q_s, g_s;
    logic       wp_w, ov_w, wp_s, ov_s;

    int checks = 0;
    int errors = 0;

    int m_q   [2];
    int m_ovf [2];
    int m_wrap[2];

    always #5 clk = ~clk;

    updown_mod_counter #(.WIDTH(4), .MAX_VAL(9), .SATURATE(0)) u_wrap (
        .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load),
        .load_val(load_val), .clr(clr),
        .q(q_w), .q_gray(g_w), .wrap_p(wp_w), .ovf(ov_w)
    );

    updown_mod_counter #(.WIDTH(4), .MAX_VAL(9), .SATURATE(1)) u_sat (
        .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load),
        .load_val(load_val), .clr(clr),
        .q(q_s), .q_gray(g_s), .wrap_p(wp_s), .ovf(ov_s)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input int qw, input int ww, input int ow,
                           input int qs, input int ws, input int os);
        chk({tag, ".q_w"}, 32'(q_w), qw);
        chk({tag, ".wp_w"}, 32'(wp_w), ww);
        chk({tag, ".ov_w"}, 32'(ov_w), ow);
        chk({tag, ".q_s"}, 32'(q_s), qs);
        chk({tag, ".wp_s"}, 32'(wp_s), ws);
        chk({tag, ".ov_s"}, 32'(ov_s), os);
    endtask

    function automatic int gray(input int v);
        return (v >> 1) ^ v;
    endfunction

    initial begin
        en = 0; up = 0; load = 0; clr = 0; load_val = 0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_all("reset", 0, 0, 0, 0, 0, 0);
        chk("reset.g_w", 32'(g_w), 0);
        chk("reset.g_s", 32'(g_s), 0);
        rst_n = 1'b1;

        // Count up 12 edges through the terminal count.
        en = 1; up = 1;
        for (int i = 1; i <= 12; i++) begin
            step();
            chk_all($sformatf("up%0d", i), i % 10, (i == 10) ? 1 : 0, (i >= 10) ? 1 : 0,
                    (i < 9) ? i : 9, (i >= 10) ? 1 : 0, (i >= 10) ? 1 : 0);
            chk($sformatf("up%0d.g_w", i), 32'(g_w), gray(i % 10));
        end

        en = 0; clr = 1;
        step();
        chk_all("clr", 0, 0, 0, 0, 0, 0);
        clr = 0;

        // Down across zero.
        en = 1; up = 0;
        step();
        chk_all("dn1", 9, 1, 1, 0, 1, 1);
        chk("dn1.g_w", 32'(g_w), 32'b1101);
        step();
        chk_all("dn2", 8, 0, 1, 0, 1, 1);
        chk("dn2.g_w", 32'(g_w), 32'b1100);

        en = 0; load = 1; load_val = 4'd9;
        step();
        chk_all("ld9", 9, 0, 1, 9, 0, 1);
        load = 0; en = 1; up = 1;
        step();
        chk_all("sat1", 0, 1, 1, 9, 1, 1);
        step();
        chk_all("sat2", 1, 0, 1, 9, 1, 1);
        step();
        chk_all("sat3", 2, 0, 1, 9, 1, 1);
        chk("sat3.g_s", 32'(g_s), 32'b1101);

        en = 0; load = 1; load_val = 4'd14;
        step();
        chk_all("ld14", 9, 0, 1, 9, 0, 1);
        clr = 1;
        step();
        chk_all("clrld", 0, 0, 0, 0, 0, 0);
        load = 0; en = 1; up = 0;
        step();
        chk_all("clrev", 0, 0, 0, 0, 0, 0);
        clr = 0; up = 1;
        repeat (5) step();
        chk_all("cnt5", 5, 0, 0, 5, 0, 0);

        // Asynchronous reset mid-cycle, released away from the edge.
        #3 rst_n = 1'b0;
        #1;
        chk_all("arst", 0, 0, 0, 0, 0, 0);
        chk("arst.g_w", 32'(g_w), 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk_all("rel", 0, 0, 0, 0, 0, 0);
        step();
        chk_all("first", 1, 0, 0, 1, 0, 0);

        // Randomized traffic against a reference model.
        for (int k = 0; k < 2; k++) begin
            m_q[k] = 1; m_ovf[k] = 0; m_wrap[k] = 0;
        end
        for (int n = 0; n < 3000; n++) begin
            en       = ($urandom_range(0, 3) != 0);
            up       = $urandom_range(0, 1) != 0;
            load     = ($urandom_range(0, 9) == 0);
            clr      = ($urandom_range(0, 24) == 0);
            load_val = 4'($urandom_range(0, 15));
            for (int k = 0; k < 2; k++) begin
                m_wrap[k] = 0;
                if (clr) begin
                    m_q[k] = 0;
                    m_ovf[k] = 0;
                end else if (load) begin
                    m_q[k] = (int'(load_val) > 9) ? 9 : int'(load_val);
                end else if (en) begin
                    if ((up && m_q[k] == 9) || (!up && m_q[k] == 0)) begin
                        m_wrap[k] = 1;
                        m_ovf[k]  = 1;
                    end
                    if (k == 0)
                        m_q[k] = up ? (m_q[k] + 1) % 10 : (m_q[k] + 9) % 10;
                    else
                        m_q[k] = up ? ((m_q[k] < 9) ? m_q[k] + 1 : 9)
                                    : ((m_q[k] > 0) ? m_q[k] - 1 : 0);
                end
            end
            step();
            chk_all("rnd", m_q[0], m_wrap[0], m_ovf[0], m_q[1], m_wrap[1], m_ovf[1]);
            chk("rnd.g_w", 32'(g_w), gray(m_q[0]));
            chk("rnd.g_s", 32'(g_s), gray(m_q[1]));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
